track_pattern_editor: RTL
=========================

# track_pattern_editor

Writer side of the step-sequencer pattern path. Holds the 16-step on/off patterns for all tracks and edits them from debounced front-panel button pulses: a cursor-based toggle in edit mode, and quantised live recording at the current playback step in record mode. Its outputs are the `track_vec` patterns that the playback step iterator reads, plus cursor and status outputs for the display.

## Interface

Parameters:
- `NUM_TRACKS`, default 4: number of patterns stored; minimum 2.
- `SEL_W`, default `$clog2(NUM_TRACKS)`: width of the track select.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock for the block.
- `reset`, in, 1: asynchronous, active-low reset. Asserted when 0.
- `btn_left`, in, 1: one-cycle pulse; moves the cursor down by 1.
- `btn_right`, in, 1: one-cycle pulse; moves the cursor up by 1.
- `btn_toggle`, in, 1: one-cycle pulse; edit action.
- `btn_rec`, in, 1: one-cycle pulse; enters or leaves record mode.
- `btn_clear`, in, 1: one-cycle pulse; clears all tracks.
- `btn_undo`, in, 1: one-cycle pulse; used only with `EDITOR_UNDO_EN`.
- `track_sel`, in, SEL_W: track being edited or displayed.
- `play_iter`, in, 4: current playback step from the iterator.
- `track_vec`, out, 16: pattern of `track_sel`. This is combinational from the registers.
- `pattern_bus`, out, 16*NUM_TRACKS: all patterns; track k occupies bits [16k+15:16k].
- `cursor`, out, 4: edit cursor.
- `rec_active`, out, 1: high in state REC.
- `busy`, out, 1: high in state CLEAR.

## Operation

- **States.** The FSM has three states: IDLE, REC and CLEAR.
- **Transitions.**
  - IDLE→REC and REC→IDLE on `btn_rec`.
  - IDLE or REC→CLEAR on `btn_clear`.
  - CLEAR→IDLE after its sweep finishes.
- **Priority within one cycle.** `btn_clear` beats `btn_rec`, which beats `btn_toggle`. A lower-priority pulse in the same cycle is dropped.
- **IDLE.** `btn_toggle` inverts bit `cursor` of the pattern for `track_sel`.
- **REC.** `btn_toggle` sets bit `play_iter` of the pattern for `track_sel`. It never clears a bit. The value of `play_iter` in the same cycle is used.
- **Cursor movement.**
  - Wraps modulo 16: 15+1=0 and 0−1=15.
  - Moves in IDLE and REC.
  - `btn_left` and `btn_right` together leave the cursor unchanged.
  - A toggle uses the cursor value from before any move in the same cycle.
- **CLEAR.**
  - A sweep index starts at 0 and zeroes one track per cycle.
  - Takes NUM_TRACKS cycles, then returns to IDLE.
  - All buttons are ignored while in CLEAR.
  - The cursor is kept; record mode is exited.
- **Out-of-range `track_sel`** (≥ NUM_TRACKS): edits are ignored and `track_vec` is 0.
- **Reset values.** All patterns 0, `cursor`=0, state IDLE, `rec_active`=0, `busy`=0. This holds in every state, including mid-CLEAR.

## Timing

- A pattern bit changes on the rising edge that samples the pulse. It is visible on `track_vec` and `pattern_bus` in the following cycle.
- `track_vec` follows `track_sel` with zero latency.
- `rec_active` and `busy` are registered state decodes. They change on the edge that takes the transition.
- `btn_clear` sampled at edge T gives `busy`=1 from T through T+NUM_TRACKS−1 and 0 from T+NUM_TRACKS.
- Pulses longer than one cycle act once per cycle. Deduplicating them is the debouncer's job, not this block's.

## Configuration

- **`EDITOR_UNDO_EN` defined:**
  - Before each accepted toggle, the previous 16-bit pattern and its track index are saved in a one-level snapshot.
  - `btn_undo` in IDLE or REC restores the snapshot and invalidates it.
  - `btn_undo` with no valid snapshot does nothing.
  - CLEAR and reset invalidate the snapshot.
  - Undo has the lowest priority, below toggle.
- **Not defined:** the `btn_undo` port stays present but is ignored, and no snapshot registers are built.

## Structure

- **Shared package `track_pkg`:** `STEPS`=16, `STEP_W`=4, and the enum `editor_state_t` {IDLE, REC, CLEAR}. The step iterator imports the same constants.
- **Sub-module `step_cursor`:** a 4-bit wrap-around up/down counter with inc/dec inputs. It is the natural split and is reusable by the display.
- **Pattern storage:** an array of NUM_TRACKS 16-bit registers, flattened onto `pattern_bus`.

## Test plan

- **Reset:** hold `reset`=0 mid-sweep, then release → all patterns 0, `cursor`=0, `busy`=0, `rec_active`=0.
- **Edit toggle:** `track_sel`=1, then `btn_right` ×3 and `btn_toggle` → `pattern_bus`[31:16]=16'h0008. A second toggle returns it to 16'h0000.
- **Cursor wrap:** `btn_left` from 0 → `cursor`=15. Then `btn_right` → 0. Then left and right together → stays 0.
- **Record:** `btn_rec`, then `btn_toggle` with `play_iter`=9 on track 2 → bit 9 set. Repeat at the same step → bit stays 1. `rec_active` is 1 throughout.
- **Clear:** with all tracks nonzero, `btn_clear` plus `btn_toggle` in the same cycle → toggle dropped, `busy` high for exactly 4 cycles, all patterns 0, state IDLE.
- **Undo (with `EDITOR_UNDO_EN`):** toggle bit 5 on track 0, then `btn_undo` → 16'h0000. A second undo makes no change.

Source files
------------

// File: rtl/track_pkg.sv
// Constants and state type shared by the pattern editor and the step iterator.
package track_pkg;

  localparam int unsigned STEPS  = 16;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    CLEAR
  } editor_state_t;

endpackage

// File: rtl/step_cursor.sv
// 4-bit wrap-around up/down step counter; simultaneous inc and dec cancel.
module step_cursor
  import track_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [STEP_W-1:0] count_o
);

  logic [STEP_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en_i && inc_i && !dec_i) begin
      count_d = count_q + STEP_W'(1);
    end else if (en_i && dec_i && !inc_i) begin
      count_d = count_q - STEP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/track_pattern_editor.sv
// Step-sequencer pattern editor: cursor toggle, quantised record, swept clear.
// Optional one-level undo is built when EDITOR_UNDO_EN is defined.
module track_pattern_editor
  import track_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_TRACKS)
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        btn_left_i,
  input  logic                        btn_right_i,
  input  logic                        btn_toggle_i,
  input  logic                        btn_rec_i,
  input  logic                        btn_clear_i,
  input  logic                        btn_undo_i,
  input  logic [SEL_W-1:0]            track_sel_i,
  input  logic [STEP_W-1:0]           play_iter_i,
  output logic [STEPS-1:0]            track_vec_o,
  output logic [STEPS*NUM_TRACKS-1:0] pattern_bus_o,
  output logic [STEP_W-1:0]           cursor_o,
  output logic                        rec_active_o,
  output logic                        busy_o
);

  editor_state_t    state_d, state_q;
  logic [SEL_W-1:0] sweep_d, sweep_q;
  logic [STEPS-1:0] pat_d [NUM_TRACKS];
  logic [STEPS-1:0] pat_q [NUM_TRACKS];
  logic             sel_valid, edit_ok, toggle_acc;

  assign sel_valid  = (32'(track_sel_i) < NUM_TRACKS);
  // Clear and record pulses swallow a toggle arriving in the same cycle.
  assign edit_ok    = (state_q != CLEAR) && !btn_clear_i && !btn_rec_i;
  assign toggle_acc = edit_ok && btn_toggle_i && sel_valid;

  step_cursor u_cursor (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .en_i    (state_q != CLEAR),
    .inc_i   (btn_right_i),
    .dec_i   (btn_left_i),
    .count_o (cursor_o)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (btn_clear_i)    state_d = CLEAR;
        else if (btn_rec_i) state_d = REC;
      end
      REC: begin
        if (btn_clear_i)    state_d = CLEAR;
        else if (btn_rec_i) state_d = IDLE;
      end
      CLEAR: begin
        if (sweep_q == SEL_W'(NUM_TRACKS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rec_active_o = (state_q == REC);
    busy_o       = (state_q == CLEAR);
  end

`ifdef EDITOR_UNDO_EN
  logic [STEPS-1:0] snap_q;
  logic [SEL_W-1:0] snap_idx_q;
  logic             snap_vld_q, undo_acc;

  assign undo_acc = edit_ok && !btn_toggle_i && btn_undo_i && snap_vld_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      snap_q     <= '0;
      snap_idx_q <= '0;
      snap_vld_q <= 1'b0;
    end else if (state_q == CLEAR || btn_clear_i) begin
      snap_vld_q <= 1'b0;
    end else if (toggle_acc) begin
      snap_q     <= pat_q[track_sel_i];
      snap_idx_q <= track_sel_i;
      snap_vld_q <= 1'b1;
    end else if (undo_acc) begin
      snap_vld_q <= 1'b0;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = btn_undo_i;
`endif

  always_comb begin
    pat_d   = pat_q;
    sweep_d = '0;
    if (state_q == CLEAR) begin
      pat_d[sweep_q] = '0;
      sweep_d        = sweep_q + SEL_W'(1);
    end else if (toggle_acc) begin
      // Toggle reads the pre-move cursor: cursor_o is the registered value.
      if (state_q == REC) begin
        pat_d[track_sel_i][play_iter_i] = 1'b1;
      end else begin
        pat_d[track_sel_i][cursor_o] = ~pat_q[track_sel_i][cursor_o];
      end
    end
`ifdef EDITOR_UNDO_EN
    else if (undo_acc) begin
      pat_d[snap_idx_q] = snap_q;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sweep_q <= '0;
      for (int k = 0; k < NUM_TRACKS; k++) pat_q[k] <= '0;
    end else begin
      sweep_q <= sweep_d;
      for (int k = 0; k < NUM_TRACKS; k++) pat_q[k] <= pat_d[k];
    end
  end

  assign track_vec_o = sel_valid ? pat_q[track_sel_i] : '0;

  for (genvar k = 0; k < NUM_TRACKS; k++) begin : g_bus
    assign pattern_bus_o[STEPS*k +: STEPS] = pat_q[k];
  end

endmodule
